// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-bank debug arbiter.
// Imported by the arbiter and by anything that needs its defaults.
package reg_bank_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_REG_ADDR_BITS = 5;
  localparam int DEF_NUM_REGS      = 32;
  localparam int DEF_DRAIN_CYCLES  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_READ,
    S_HOLD,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/reg_bank_arbiter.sv
// Arbitrates register-bank port A between the decode stage and a debug
// dump engine that streams every register out over a valid/ready link.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_ADDR_BITS-1:0] id_addr_a_in,
  input  logic [REG_ADDR_BITS-1:0] id_addr_b_in,
  input  logic                     wb_write_w_in,
  input  logic [REG_ADDR_BITS-1:0] wb_addr_w_in,
  input  logic [DATA_WIDTH-1:0]    wb_data_in,
  input  logic [DATA_WIDTH-1:0]    rb_a_data_in,
  input  logic                     dbg_dump_req,
  input  logic                     dbg_ready,
  output logic [REG_ADDR_BITS-1:0] rb_addr_a_out,
  output logic [REG_ADDR_BITS-1:0] rb_addr_b_out,
  output logic                     rb_write_w_out,
  output logic [REG_ADDR_BITS-1:0] rb_addr_w_out,
  output logic [DATA_WIDTH-1:0]    rb_w_data_out,
  output logic                     stall_out,
  output logic                     dbg_valid,
  output logic [DATA_WIDTH-1:0]    dbg_data,
  output logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic                     dbg_done
);

  localparam logic [REG_ADDR_BITS-1:0] LAST_IDX =
    REG_ADDR_BITS'(NUM_REGS - 1);
  localparam logic [REG_ADDR_BITS-1:0] DRAIN_INIT =
    REG_ADDR_BITS'(DRAIN_CYCLES - 1);

  arb_state_t               r_state;
  arb_state_t               w_next;
  logic [REG_ADDR_BITS-1:0] r_idx;
  logic [REG_ADDR_BITS-1:0] r_cnt;
  logic                     r_stall;
  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [REG_ADDR_BITS-1:0] r_addr;
  logic                     r_done;
  logic                     w_accept;
  logic                     w_dump_port;

  assign w_accept = (r_state == S_HOLD) && r_valid && dbg_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (dbg_dump_req) w_next = S_DRAIN;
      S_DRAIN: if (r_cnt == '0) w_next = S_READ;
      S_READ:  w_next = S_HOLD;
      S_HOLD: begin
        if (w_accept)
          w_next = (r_idx == LAST_IDX) ? S_DONE : S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stall <= (w_next != S_IDLE);
      r_done  <= w_accept && (r_idx == LAST_IDX);
      unique case (r_state)
        S_IDLE: begin
          if (dbg_dump_req) begin
            r_cnt <= DRAIN_INIT;
            r_idx <= '0;
          end
        end
        S_DRAIN: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_READ: begin
          r_data  <= rb_a_data_in;
          r_addr  <= r_idx;
          r_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Dump engine owns port A from the first read until it returns to idle.
  always_comb begin
    w_dump_port = 1'b0;
    unique case (1'b1)
      (r_state == S_READ),
      (r_state == S_HOLD),
      (r_state == S_DONE): w_dump_port = 1'b1;
      default:             w_dump_port = 1'b0;
    endcase
  end

  assign rb_addr_a_out  = w_dump_port ? r_idx : id_addr_a_in;
  assign rb_addr_b_out  = id_addr_b_in;
  assign rb_write_w_out = wb_write_w_in;
  assign rb_addr_w_out  = wb_addr_w_in;
  assign rb_w_data_out  = wb_data_in;

  assign stall_out = r_stall;
  assign dbg_valid = r_valid;
  assign dbg_data  = r_data;
  assign dbg_addr  = r_addr;
  assign dbg_done  = r_done;

endmodule
